// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam state_t RST_STATE = IDLE;
  localparam logic   RST_NEG   = 1'b0;

  // Counter must hold WIDTH itself, hence WIDTH+1 codes.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_shift_add_step.sv
// One shift-add iteration: conditionally add the multiplicand into the high
// half through a ripple adder, then shift the whole accumulator right by one.
module mult_shift_add_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   accHi,
  input  logic [WIDTH-1:0] accLo,
  input  logic [WIDTH-1:0] magA,
  output logic [WIDTH:0]   nextHi,
  output logic [WIDTH-1:0] nextLo
);

  logic [WIDTH-1:0] addend;
  logic [WIDTH:0]   sum;
  logic             carry;

  always_comb begin
    addend = accLo[0] ? magA : '0;
    carry  = 1'b0;
    sum    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = accHi[i] ^ addend[i] ^ carry;
      carry  = (accHi[i] & addend[i]) | (carry & (accHi[i] ^ addend[i]));
    end
    // accHi[WIDTH] is always 0 after a shift, so this is just the carry-out.
    sum[WIDTH] = accHi[WIDTH] ^ carry;
    {nextHi, nextLo} = {sum, accLo} >> 1;
  end

endmodule

// File: rtl/multiplier_seq_nbit.sv
// Iterative WIDTH x WIDTH -> 2*WIDTH shift-add multiplier with valid/ready on
// both sides. Define MULT_SIGNED_EN to honour io_signed (two's-complement).
module multiplier_seq_nbit
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               io_in_valid,
  output logic               io_in_ready,
  input  logic [WIDTH-1:0]   io_a,
  input  logic [WIDTH-1:0]   io_b,
  input  logic               io_signed,
  output logic               io_out_valid,
  input  logic               io_out_ready,
  output logic [2*WIDTH-1:0] io_result
);

  localparam int CW = cntWidth(WIDTH);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  state_t             state, stateNext;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   magA, accLo, stepLo, magAIn, magBIn;
  logic [WIDTH:0]     accHi, stepHi;
  logic [2*WIDTH-1:0] result, product, resultNext;
  logic               accept, lastStep;

  assign accept   = (state == IDLE) && io_in_valid;
  assign lastStep = (state == BUSY) && (cnt == CW'(1));
  assign product  = {stepHi[WIDTH-1:0], stepLo};

`ifdef MULT_SIGNED_EN
  logic neg, negIn;

  assign magAIn = (io_signed && io_a[WIDTH-1]) ? (~io_a + 1'b1) : io_a;
  assign magBIn = (io_signed && io_b[WIDTH-1]) ? (~io_b + 1'b1) : io_b;
  assign negIn  = io_signed & (io_a[WIDTH-1] ^ io_b[WIDTH-1]);
  assign resultNext = neg ? (~product + 1'b1) : product;

  always_ff @(posedge clock) begin
    if (!reset)      neg <= RST_NEG;
    else if (accept) neg <= negIn;
  end
`else
  logic unusedSigned;

  assign unusedSigned = io_signed;
  assign magAIn       = io_a;
  assign magBIn       = io_b;
  assign resultNext   = product;
`endif

  mult_shift_add_step #(.WIDTH(WIDTH)) uStep (
    .accHi  (accHi),
    .accLo  (accLo),
    .magA   (magA),
    .nextHi (stepHi),
    .nextLo (stepLo)
  );

  always_ff @(posedge clock) begin
    if (!reset) state <= RST_STATE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (io_in_valid)  stateNext = BUSY;
      BUSY:    if (lastStep)     stateNext = DONE;
      DONE:    if (io_out_ready) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Result is registered on the last iteration so DONE has no arithmetic path.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt    <= '0;
      magA   <= '0;
      accHi  <= '0;
      accLo  <= '0;
      result <= '0;
    end else if (accept) begin
      magA  <= magAIn;
      accHi <= '0;
      accLo <= magBIn;
      cnt   <= CNT_INIT;
    end else if (state == BUSY) begin
      accHi <= stepHi;
      accLo <= stepLo;
      cnt   <= cnt - 1'b1;
      if (lastStep) result <= resultNext;
    end
  end

  assign io_in_ready  = (state == IDLE);
  assign io_out_valid = (state == DONE);
  assign io_result    = result;

endmodule

// File: tb/tb_multiplier_seq_nbit.sv
// Self-checking bench for multiplier_seq_nbit (WIDTH=8): directed table,
// randomized ops against an arithmetic model, and multi-cycle corner cases.
module tb_multiplier_seq_nbit;
  localparam int W = 8;
`ifdef MULT_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           io_in_valid = 1'b0;
  logic           io_signed = 1'b0;
  logic           io_out_ready = 1'b0;
  logic [W-1:0]   io_a = '0;
  logic [W-1:0]   io_b = '0;
  logic           io_in_ready, io_out_valid;
  logic [2*W-1:0] io_result;

  int nChecks = 0;
  int nPass = 0;

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [2*W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  multiplier_seq_nbit #(.WIDTH(W)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_a         (io_a),
    .io_b         (io_b),
    .io_signed    (io_signed),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_result    (io_result)
  );

  always #5 clock = ~clock;

  function automatic logic [2*W-1:0] refMul(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (s && SIGNED_EN) begin
      if (a[W-1]) sa = sa - (longint'(1) << W);
      if (b[W-1]) sb = sb - (longint'(1) << W);
    end
    p = sa * sb;
    return p[2*W-1:0];
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    nChecks++;
    if (act == exp) nPass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic timeoutFail(input string name);
    nChecks++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Issue one op, measure edges from accept to io_out_valid, then complete it.
  task automatic runOp(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       output logic [2*W-1:0] res, output int lat);
    int guard = 0;
    while (!io_in_ready && guard < 50) begin
      @(posedge clock); #1; guard++;
    end
    io_a = a; io_b = b; io_signed = s; io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    io_a = W'($urandom); io_b = W'($urandom); io_signed = 1'($urandom);
    lat = 0;
    while (!io_out_valid && lat < 100) begin
      @(posedge clock); #1; lat++;
    end
    res = io_result;
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
  endtask

  task automatic opCheck(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [2*W-1:0] exp);
    logic [2*W-1:0] res;
    int lat;
    runOp(a, b, s, res, lat);
    check({name, " result"}, res, exp);
    check({name, " latency"}, lat, W);
    check({name, " ready after"}, io_in_ready, 1);
  endtask

  initial begin
    logic [2*W-1:0] q[$];
    int accCyc[$];
    logic [2*W-1:0] exp;
    int guard;

    vecs.push_back('{"u 13x11",   8'd13, 8'd11, 1'b0, 16'h008F});
    vecs.push_back('{"u ffxff",   8'hFF, 8'hFF, 1'b0, 16'hFE01});
    vecs.push_back('{"u 0xa5",    8'h00, 8'hA5, 1'b0, 16'h0000});
    vecs.push_back('{"u fdx05",   8'hFD, 8'h05, 1'b0, 16'h04F1});
`ifdef MULT_SIGNED_EN
    vecs.push_back('{"s -3x5",    8'hFD, 8'h05, 1'b1, 16'hFFF1});
    vecs.push_back('{"s 80x80",   8'h80, 8'h80, 1'b1, 16'h4000});
    vecs.push_back('{"s 80x01",   8'h80, 8'h01, 1'b1, 16'hFF80});
`else
    vecs.push_back('{"nosgn fdx05", 8'hFD, 8'h05, 1'b1, 16'h04F1});
`endif

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("reset in_ready", io_in_ready, 1);
    check("reset out_valid", io_out_valid, 0);
    check("reset result", io_result, 0);
    reset = 1'b1;
    @(posedge clock); #1;

    foreach (vecs[i]) opCheck(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].exp);

    // Backpressure: result and valid hold, no accept while DONE
    io_a = 8'h9C; io_b = 8'h37; io_signed = 1'b0; io_in_valid = 1'b1;
    exp = refMul(8'h9C, 8'h37, 1'b0);
    @(posedge clock); #1;
    io_a = 8'h11; io_b = 8'h22;
    guard = 0;
    while (!io_out_valid && guard < 100) begin
      @(posedge clock); #1; guard++;
    end
    if (guard >= 100) timeoutFail("bp wait valid");
    check("bp first result", io_result, exp);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check("bp hold result", io_result, exp);
      check("bp hold valid", io_out_valid, 1);
      check("bp hold in_ready", io_in_ready, 0);
    end
    io_in_valid = 1'b0;
    io_out_ready = 1'b1;
    @(posedge clock); #1;
    io_out_ready = 1'b0;
    check("bp release in_ready", io_in_ready, 1);
    check("bp release valid", io_out_valid, 0);

    // Back-to-back with operands changing every cycle: 10-cycle issue interval
    io_out_ready = 1'b1;
    io_in_valid = 1'b1;
    for (int cyc = 0; cyc < 45; cyc++) begin
      io_a = W'($urandom); io_b = W'($urandom); io_signed = 1'($urandom);
      if (io_in_ready) begin
        q.push_back(refMul(io_a, io_b, io_signed));
        accCyc.push_back(cyc);
      end
      if (io_out_valid && q.size() > 0) check("b2b result", io_result, q.pop_front());
      @(posedge clock); #1;
    end
    io_in_valid = 1'b0;
    guard = 0;
    while (q.size() > 0 && guard < 100) begin
      if (io_out_valid) check("b2b drain result", io_result, q.pop_front());
      @(posedge clock); #1; guard++;
    end
    if (q.size() > 0) timeoutFail("b2b drain");
    io_out_ready = 1'b0;
    check("b2b accept count", accCyc.size(), 5);
    for (int i = 1; i < accCyc.size(); i++)
      check("b2b interval", accCyc[i] - accCyc[i-1], W + 2);

    // Reset three cycles into an operation
    @(posedge clock); #1;
    io_a = 8'h55; io_b = 8'h66; io_signed = 1'b0; io_in_valid = 1'b1;
    @(posedge clock); #1;
    io_in_valid = 1'b0;
    repeat (2) @(posedge clock);
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("midrst in_ready", io_in_ready, 1);
    check("midrst out_valid", io_out_valid, 0);
    check("midrst result", io_result, 0);
    reset = 1'b1;
    opCheck("after rst 7x6", 8'd7, 8'd6, 1'b0, 16'h002A);

    // Randomized against the arithmetic model
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic rs;
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      if (i == 0) begin ra = 8'h80; rb = 8'h80; end
      opCheck("random", ra, rb, rs, refMul(ra, rb, rs));
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
